// File: rtl/key_press_conditioner.sv
// Push-button conditioner: two-flop synchroniser, counter-based debounce FSM,
// one-cycle press pulse, debounced level and a wrapping press counter.
module key_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int COUNT_W         = 8
) (
    input  logic               i_gclk,
    input  logic               i_grst_n,
    input  logic               i_key_raw,
    input  logic               i_en,
    output logic               o_press,
    output logic               o_held,
    output logic [COUNT_W-1:0] o_press_count
);

    // Raw level of an idle (released) key; the sync flops reset to it.
    localparam logic             KEY_REL  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPRESS,
        S_PRESSED,
        S_CREL
    } state_t;

    logic               r_sync1, r_sync2;
    logic               w_pressed;
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               w_cnt_last;
    logic               w_press_d, w_held_d;
    logic               r_press, r_held;
    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n) begin
            r_sync1 <= KEY_REL;
            r_sync2 <= KEY_REL;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed  = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Any disagreeing sample during a confirm phase restarts qualification.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pressed) begin
                    w_next     = S_CPRESS;
                    w_cnt_next = '0;
                end
            end
            S_CPRESS: begin
                if (!w_pressed) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else if (w_cnt_last) begin
                    w_next = S_PRESSED;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!w_pressed) begin
                    w_next     = S_CREL;
                    w_cnt_next = '0;
                end
            end
            S_CREL: begin
                if (w_pressed) begin
                    w_next     = S_PRESSED;
                    w_cnt_next = '0;
                end else if (w_cnt_last) begin
                    w_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // A press qualified while disabled is dropped, never deferred.
    always_comb begin
        w_press_d = (r_state == S_CPRESS) && w_pressed && w_cnt_last && i_en;
        w_held_d  = (w_next == S_PRESSED) || (w_next == S_CREL);
    end

    always_ff @(posedge i_gclk or negedge i_grst_n) begin
        if (!i_grst_n) begin
            r_press <= 1'b0;
            r_held  <= 1'b0;
            r_count <= '0;
        end else begin
            r_press <= w_press_d;
            r_held  <= w_held_d;
            if (w_press_d) r_count <= r_count + COUNT_W'(1);
        end
    end

    assign o_press       = r_press;
    assign o_held        = r_held;
    assign o_press_count = r_count;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench: an active-low DEBOUNCE=4 instance and an active-high
// DEBOUNCE=1, 2-bit-counter instance sharing clock and reset.
module tb_key_press_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_a, en_a, press_a, held_a;
    logic [7:0] cnt_a;
    logic       key_b, en_b, press_b, held_b;
    logic [1:0] cnt_b;

    int n_chk = 0;
    int n_bad = 0;
    int pc_a  = 0;
    int pc_b  = 0;
    int base;

    always #5 clk = ~clk;

    key_press_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .ACTIVE_LOW(1), .COUNT_W(8)) u_dut_a (
        .i_gclk(clk), .i_grst_n(rst_n), .i_key_raw(key_a), .i_en(en_a),
        .o_press(press_a), .o_held(held_a), .o_press_count(cnt_a)
    );

    key_press_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4), .ACTIVE_LOW(0), .COUNT_W(2)) u_dut_b (
        .i_gclk(clk), .i_grst_n(rst_n), .i_key_raw(key_b), .i_en(en_b),
        .o_press(press_b), .o_held(held_b), .o_press_count(cnt_b)
    );

    always @(negedge clk) begin
        if (rst_n && press_a) pc_a++;
        if (rst_n && press_b) pc_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; key_a = 1'b1; en_a = 1'b1; key_b = 1'b0; en_b = 1'b1;

        // Reset held with toggling keys: everything stays cleared.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            key_a = ~key_a; key_b = ~key_b;
            chk("rst_press_a", press_a, 0);
            chk("rst_held_a", held_a, 0);
            chk("rst_cnt_a", cnt_a, 0);
            chk("rst_cnt_b", cnt_b, 0);
        end
        key_a = 1'b1; key_b = 1'b0;
        rst_n = 1'b1;
        tick(4);
        chk("idle_held_a", held_a, 0);
        chk("idle_press_a", press_a, 0);

        // Clean press: pulse at edge 7 only.
        key_a = 1'b0;
        tick(6);
        chk("clean_e6_press", press_a, 0);
        chk("clean_e6_held", held_a, 0);
        tick(1);
        chk("clean_e7_press", press_a, 1);
        chk("clean_e7_held", held_a, 1);
        chk("clean_e7_cnt", cnt_a, 1);
        tick(1);
        chk("clean_e8_press", press_a, 0);
        tick(12);
        chk("clean_hold_cnt", cnt_a, 1);
        chk("clean_hold_pulses", pc_a, 1);
        key_a = 1'b1;
        tick(6);
        chk("rel_e6_held", held_a, 1);
        tick(1);
        chk("rel_e7_held", held_a, 0);
        tick(13);
        chk("rel_pulses", pc_a, 1);

        // Bounce on press: 3 low, 1 high, 3 low, 1 high, then stable low.
        base = pc_a;
        key_a = 1'b0; tick(3);
        key_a = 1'b1; tick(1);
        key_a = 1'b0; tick(3);
        key_a = 1'b1; tick(1);
        key_a = 1'b0;
        tick(6);
        chk("bnc_e6_press", press_a, 0);
        chk("bnc_e6_pulses", pc_a - base, 0);
        tick(1);
        chk("bnc_e7_press", press_a, 1);
        chk("bnc_cnt", cnt_a, 2);
        tick(10);
        chk("bnc_pulses", pc_a - base, 1);

        // Bounce on release: short pressed glitches keep held high.
        key_a = 1'b1; tick(2);
        key_a = 1'b0; tick(1);
        key_a = 1'b1; tick(2);
        key_a = 1'b0; tick(1);
        key_a = 1'b1;
        tick(2);
        chk("rbnc_held", held_a, 1);
        tick(4);
        chk("rbnc_e6_held", held_a, 1);
        tick(1);
        chk("rbnc_e7_held", held_a, 0);
        chk("rbnc_pulses", pc_a - base, 1);
        tick(10);

        // Enable low for a whole press: held follows, no pulse, count frozen.
        en_a = 1'b0; key_a = 1'b0;
        tick(10);
        chk("en0_held", held_a, 1);
        chk("en0_cnt", cnt_a, 2);
        chk("en0_pulses", pc_a - base, 1);
        key_a = 1'b1; tick(12);
        en_a = 1'b1; key_a = 1'b0;
        tick(7);
        chk("en1_press", press_a, 1);
        chk("en1_cnt", cnt_a, 3);
        key_a = 1'b1; tick(12);

        // Enable low only at the qualifying edge: press is lost for good.
        key_a = 1'b0;
        tick(6);
        en_a = 1'b0;
        tick(1);
        chk("enq_press", press_a, 0);
        chk("enq_held", held_a, 1);
        en_a = 1'b1;
        tick(8);
        chk("enq_cnt", cnt_a, 3);
        key_a = 1'b1; tick(12);

        // Reset in CONFIRM_PRESS, key held through deassert.
        key_a = 1'b0;
        tick(4);
        rst_n = 1'b0; #1;
        chk("rcp_press", press_a, 0);
        chk("rcp_held", held_a, 0);
        chk("rcp_cnt", cnt_a, 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("rcp_e6_press", press_a, 0);
        tick(1);
        chk("rcp_e7_press", press_a, 1);
        chk("rcp_e7_cnt", cnt_a, 1);

        // Reset on the press cycle itself: outputs clear without a clock edge.
        #2 rst_n = 1'b0; #1;
        chk("rpc_press", press_a, 0);
        chk("rpc_held", held_a, 0);
        chk("rpc_cnt", cnt_a, 0);
        tick(1);
        rst_n = 1'b1;
        tick(7);
        chk("rpc_e7_press", press_a, 1);
        chk("rpc_e7_cnt", cnt_a, 1);
        key_a = 1'b1; tick(12);

        // Active-high, single-sample debounce, 2-bit wrapping counter.
        base = pc_b;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_cnt;
            exp_cnt = 2'(i + 1);
            key_b = 1'b1;
            tick(3);
            chk("b_e3_press", press_b, 0);
            tick(1);
            chk("b_e4_press", press_b, 1);
            chk("b_e4_held", held_b, 1);
            chk("b_cnt", cnt_b, exp_cnt);
            tick(2);
            key_b = 1'b0;
            tick(3);
            chk("b_rel_e3_held", held_b, 1);
            tick(1);
            chk("b_rel_e4_held", held_b, 0);
            tick(2);
        end
        chk("b_pulses", pc_b - base, 5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Upstream stage of the moving-light chain: turns a raw, bouncy, asynchronous push-button into clean control signals for the light cells.
- Synchronises the key, debounces it with a counter-based FSM, and emits a one-cycle press pulse per accepted physical press.
- Also provides a debounced level and a wrapping press counter for score/debug logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a press or release; legal range 1..2^CNT_W.
- CNT_W, 16, width of the debounce counter.
- ACTIVE_LOW, 1, 1 = key_raw low means pressed (board KEY convention); 0 = high means pressed.
- COUNT_W, 8, width of press_count.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- key_raw  input  1  raw, asynchronous button level.
- en  input  1  1 = press pulses and counting allowed; 0 = FSM still tracks the key, but press is forced 0 and the count is frozen.
- press  output  1  registered one-cycle pulse per accepted press.
- held  output  1  registered debounced level; 1 while the FSM is in PRESSED or CONFIRM_RELEASE.
- press_count  output  COUNT_W  number of pulses issued; wraps from all-ones to 0.

Behaviour:
- Synchroniser:
  - Two flops on key_raw, then polarity normalisation (pressed = 1 internally).
  - Both flops reset to the released value.
- FSM states: IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE. Reset state is IDLE with cnt=0.
- IDLE:
  - sync pressed -> CONFIRM_PRESS, cnt<=0.
  - Otherwise stay.
- CONFIRM_PRESS:
  - sync released -> IDLE, cnt<=0. A bounce restarts qualification from scratch.
  - sync pressed and cnt==DEBOUNCE_CYCLES-1 -> PRESSED.
  - Otherwise cnt<=cnt+1.
- PRESSED:
  - sync released -> CONFIRM_RELEASE, cnt<=0.
  - Otherwise stay. A held key never produces a second pulse.
- CONFIRM_RELEASE:
  - sync pressed -> PRESSED, with no new pulse.
  - sync released and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise cnt<=cnt+1.
- press pulse:
  - Registered 1 for exactly the cycle following the CONFIRM_PRESS->PRESSED transition, and only if en==1 at that transition edge. Otherwise 0.
- press_count:
  - Increments on the same edge that sets press, modulo 2^COUNT_W.
- Latency: number edges from the first rising edge that samples a stable pressed key_raw (edge 1).
  - Sync output valid after edge 2; CONFIRM_PRESS entered at edge 3.
  - PRESSED entered, and press=1 and held=1, at edge 3+DEBOUNCE_CYCLES.
  - press returns to 0 at edge 4+DEBOUNCE_CYCLES.
  - Release is symmetric: held falls at edge 3+DEBOUNCE_CYCLES after a stable release.
- Reset values: press=0, held=0, press_count=0, FSM IDLE, sync flops released, cnt=0.
- Reset is asynchronous: assertion clears all outputs immediately, mid-pulse or mid-confirm included.
- If the key is still held when Reset deasserts, the key is requalified from IDLE. One press pulse is issued at edge 3+DEBOUNCE_CYCLES after release of reset.
- en toggling mid-press: only en at the qualifying edge matters. A press qualified while en=0 is lost, not deferred.
- DEBOUNCE_CYCLES=1: a single stable synchronised sample qualifies. Pulse at edge 4.
- No combinational path from key_raw or en to any output.

Test Plan:
- Reset sequence: Reset=0 for 3 cycles with key_raw toggling -> press=0, held=0, press_count=0 throughout; FSM IDLE after Reset=1.
- Clean press: ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, key_raw 1->0 held for 20 cycles -> press=1 for exactly one cycle after edge 7; held=1 from edge 7; press_count=1. Then release for 20 cycles -> held=0 after edge 7 of the release, no extra pulse.
- Bounce rejection: key_raw pressed for 3 cycles, released 1, pressed 3, released 1, then pressed stable -> no pulse until 4 consecutive synchronised pressed samples; exactly one pulse total. Bounce during release (1-cycle pressed glitches) -> held stays 1, no new pulse.
- Enable gating: en=0 during a clean press -> held rises, press stays 0, press_count unchanged. en=1 on the next press -> one pulse, count+1.
- Counter wrap: COUNT_W=2, 5 clean presses -> press_count 1,2,3,0,1; 5 pulses.
- Reset mid-operation: assert Reset while in CONFIRM_PRESS, and again on the press cycle -> press drops immediately, count=0. Key still held at deassert -> one pulse at edge 3+DEBOUNCE_CYCLES after deassert.
